// File: rtl/rca_pipe_sched.sv
// Round-robin front end for one shared 8-bit pipelined adder; tags ride alongside the adder pipe.
// Grant to response is LATENCY+1 cycles; requesters wait on req_ready (hold stalls grants), responses are never stalled.
module rca_pipe_sched #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 9,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic              add_cin,
  input  logic [7:0]        add_sum,
  input  logic              add_cout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_sum,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        inflight
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] ptr;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  int             idx;
  tag_t           tag_q [LATENCY];
  logic           rsp_any;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
    if (hold || rst) begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
    end
  end

  assign req_ready = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
  assign add_a     = gnt_vld ? req_a[int'(gnt_id)*8 +: 8] : 8'd0;
  assign add_b     = gnt_vld ? req_b[int'(gnt_id)*8 +: 8] : 8'd0;
  assign add_cin   = gnt_vld ? req_cin[gnt_id] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDW'(NREQ - 1);
    end else if (gnt_vld) begin
      ptr <= gnt_id;
    end
  end

  // The adder datapath has no reset, so only these tags decide what is real.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= {gnt_vld, gnt_id};
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_sum   <= 8'd0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else if (tag_q[LATENCY-1].vld) begin
      rsp_valid <= NREQ'(1) << tag_q[LATENCY-1].id;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
      rsp_id    <= tag_q[LATENCY-1].id;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign rsp_any = |rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 4'd0;
    end else begin
      case ({gnt_vld, rsp_any})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_pipe_sched.sv
// Bench for rca_pipe_sched: behavioural adder pipe plus a queue-based scoreboard of expected responses.
module tb_rca_pipe_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 9;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst, hold;
  logic [NREQ-1:0]   req_valid, req_ready, req_cin;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [7:0]        add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        inflight;

  rca_pipe_sched #(.NREQ(NREQ), .LATENCY(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Shared adder: LAT register stages, no reset.
  logic [8:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_sum  = apipe[LAT-1][7:0];
  assign add_cout = apipe[LAT-1][8];

  typedef struct {
    int         due;
    int         id;
    logic [8:0] res;
  } exp_t;

  exp_t            q[$];
  int              cyc, mptr, m_gnt, m_infl;
  int              n_cmp, n_fail;
  logic [NREQ-1:0] m_ready, m_rvalid;
  logic [7:0]      m_sum;
  logic            m_cout;
  logic [IDW-1:0]  m_id;
  logic [16:0]     m_add;
  logic [8:0]      m_res;

  task automatic model_eval();
    @(negedge clk);
    if (rst) begin
      q.delete();
      mptr   = NREQ - 1;
      m_sum  = 8'd0;
      m_cout = 1'b0;
      m_id   = '0;
    end
    m_gnt = -1;
    if (!rst && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (mptr + k) % NREQ;
        if (m_gnt < 0 && req_valid[i]) m_gnt = i;
      end
    end
    m_ready = (m_gnt >= 0) ? (NREQ'(1) << m_gnt) : '0;
    m_add   = 17'd0;
    m_res   = 9'd0;
    if (m_gnt >= 0) begin
      m_add = {req_cin[m_gnt], req_b[m_gnt*8 +: 8], req_a[m_gnt*8 +: 8]};
      m_res = 9'(int'(req_a[m_gnt*8 +: 8]) + int'(req_b[m_gnt*8 +: 8]) + int'(req_cin[m_gnt]));
    end
    m_rvalid = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      m_rvalid = NREQ'(1) << q[0].id;
      m_sum    = q[0].res[7:0];
      m_cout   = q[0].res[8];
      m_id     = IDW'(q[0].id);
    end
    m_infl = q.size();
  endtask

  task automatic model_commit();
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    if (m_gnt >= 0) begin
      q.push_back('{cyc + LAT + 1, m_gnt, m_res});
      mptr = m_gnt;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_ops();
    req_a   = $urandom;
    req_b   = $urandom;
    req_cin = NREQ'($urandom);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      req_valid = 4'b1111;
      model_eval();
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset.ready cyc=%0d got=%b exp=0000", cyc, req_ready); end
      n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== 15'd0) begin n_fail++; $display("FAIL reset.rsp cyc=%0d got=%b/%b/%h/%0d exp=0", cyc, rsp_valid, rsp_cout, rsp_sum, rsp_id); end
      n_cmp++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL reset.inflight cyc=%0d got=%0d exp=0", cyc, inflight); end
      model_commit();
    end
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    for (int c = 0; c < 14; c++) begin
      rand_ops();
      req_valid = '0;
      if (c == 0) begin
        req_valid = 4'b0100;
        req_a[23:16] = 8'h7F;
        req_b[23:16] = 8'h01;
        req_cin[2]   = 1'b0;
      end
      model_eval();
      n_cmp++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL single.ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready); end
      n_cmp++; if ({add_cin, add_b, add_a} !== m_add) begin n_fail++; $display("FAIL single.addbus cyc=%0d got=%h exp=%h", cyc, {add_cin, add_b, add_a}, m_add); end
      n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {m_rvalid, m_cout, m_sum, m_id}) begin n_fail++; $display("FAIL single.rsp cyc=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", cyc, rsp_valid, rsp_cout, rsp_sum, rsp_id, m_rvalid, m_cout, m_sum, m_id); end
      n_cmp++; if (inflight !== 4'(m_infl)) begin n_fail++; $display("FAIL single.inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_infl); end
      if (c == 10) begin
        n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {4'b0100, 1'b0, 8'h80, 2'd2}) begin n_fail++; $display("FAIL single.t10 got=%b/%b/%h/%0d exp=0100/0/80/2", rsp_valid, rsp_cout, rsp_sum, rsp_id); end
      end
      model_commit();
    end
  endtask

  task automatic test_carry();
    for (int c = 0; c < 13; c++) begin
      rand_ops();
      req_valid = '0;
      if (c < 2) begin
        req_valid  = 4'b0001;
        req_a[7:0] = 8'hFF;
        req_b[7:0] = (c == 0) ? 8'h01 : 8'hFF;
        req_cin[0] = 1'b1;
      end
      model_eval();
      n_cmp++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL carry.ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready); end
      n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {m_rvalid, m_cout, m_sum, m_id}) begin n_fail++; $display("FAIL carry.rsp cyc=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", cyc, rsp_valid, rsp_cout, rsp_sum, rsp_id, m_rvalid, m_cout, m_sum, m_id); end
      n_cmp++; if (inflight !== 4'(m_infl)) begin n_fail++; $display("FAIL carry.inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_infl); end
      if (c == 10 || c == 11) begin
        n_cmp++; if ({rsp_cout, rsp_sum} !== ((c == 10) ? 9'h101 : 9'h1FF)) begin n_fail++; $display("FAIL carry.value cyc=%0d got=%b/%h", cyc, rsp_cout, rsp_sum); end
      end
      model_commit();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 52; c++) begin
      rand_ops();
      req_valid = (c < 40) ? 4'b1111 : 4'b0000;
      model_eval();
      n_cmp++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL b2b.ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready); end
      n_cmp++; if ({add_cin, add_b, add_a} !== m_add) begin n_fail++; $display("FAIL b2b.addbus cyc=%0d got=%h exp=%h", cyc, {add_cin, add_b, add_a}, m_add); end
      n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {m_rvalid, m_cout, m_sum, m_id}) begin n_fail++; $display("FAIL b2b.rsp cyc=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", cyc, rsp_valid, rsp_cout, rsp_sum, rsp_id, m_rvalid, m_cout, m_sum, m_id); end
      n_cmp++; if (inflight !== 4'(m_infl)) begin n_fail++; $display("FAIL b2b.inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_infl); end
      if (c == 30) begin
        n_cmp++; if (inflight !== 4'd10) begin n_fail++; $display("FAIL b2b.saturate got=%0d exp=10", inflight); end
      end
      model_commit();
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 20; c++) begin
      rand_ops();
      hold      = (c >= 3 && c < 8);
      req_valid = (c == 0) ? 4'b0010 : (c < 8) ? 4'b1010 : 4'b0000;
      model_eval();
      n_cmp++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL hold.ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready); end
      n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {m_rvalid, m_cout, m_sum, m_id}) begin n_fail++; $display("FAIL hold.rsp cyc=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", cyc, rsp_valid, rsp_cout, rsp_sum, rsp_id, m_rvalid, m_cout, m_sum, m_id); end
      n_cmp++; if (inflight !== 4'(m_infl)) begin n_fail++; $display("FAIL hold.inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_infl); end
      if (c == 1 || c == 2) begin
        n_cmp++; if (req_ready !== ((c == 1) ? 4'b1000 : 4'b0010)) begin n_fail++; $display("FAIL hold.rrorder cyc=%0d got=%b", cyc, req_ready); end
      end
      model_commit();
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 24; c++) begin
      rand_ops();
      rst       = (c == 9);
      req_valid = (c < 6) ? NREQ'($urandom_range(1, 15)) : (c == 11) ? 4'b1000 : 4'b0000;
      model_eval();
      n_cmp++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL rstmid.ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready); end
      n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {m_rvalid, m_cout, m_sum, m_id}) begin n_fail++; $display("FAIL rstmid.rsp cyc=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", cyc, rsp_valid, rsp_cout, rsp_sum, rsp_id, m_rvalid, m_cout, m_sum, m_id); end
      n_cmp++; if (inflight !== 4'(m_infl)) begin n_fail++; $display("FAIL rstmid.inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_infl); end
      model_commit();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 312; c++) begin
      rand_ops();
      hold      = (c < 300) && ($urandom_range(0, 7) == 0);
      req_valid = (c < 300) ? NREQ'($urandom) : 4'b0000;
      model_eval();
      n_cmp++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL rand.ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready); end
      n_cmp++; if ({add_cin, add_b, add_a} !== m_add) begin n_fail++; $display("FAIL rand.addbus cyc=%0d got=%h exp=%h", cyc, {add_cin, add_b, add_a}, m_add); end
      n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {m_rvalid, m_cout, m_sum, m_id}) begin n_fail++; $display("FAIL rand.rsp cyc=%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", cyc, rsp_valid, rsp_cout, rsp_sum, rsp_id, m_rvalid, m_cout, m_sum, m_id); end
      n_cmp++; if (inflight !== 4'(m_infl)) begin n_fail++; $display("FAIL rand.inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_infl); end
      model_commit();
    end
    hold = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    cyc       = 0;
    mptr      = NREQ - 1;
    m_sum     = 8'd0;
    m_cout    = 1'b0;
    m_id      = '0;
    n_cmp     = 0;
    n_fail    = 0;
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_pipe_sched.md
Name: rca_pipe_sched

Overview:
- Round-robin scheduler that shares one 8-bit pipelined ripple-carry adder (9-stage, fully pipelined, one new operation per cycle, no reset) among NREQ requesters.
- Arbitrates operand requests and drives the adder's a/b/cin inputs.
- Carries a requester tag alongside the adder's pipeline and returns each sum/cout to its originator as a registered response.
- Sits between the requester blocks and the shared adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 9, adder input-to-output register depth (ir, pr1..pr7, OR).
- IDW, 2, requester id width, at least clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- hold  in  1  when 1, no new grants; in-flight operations continue.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant; transfer when valid&ready.
- req_a  in  8*NREQ  packed operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  packed operand B.
- req_cin  in  NREQ  per-requester carry-in.
- add_a  out  8  to adder a.
- add_b  out  8  to adder b.
- add_cin  out  1  to adder cin.
- add_sum  in  8  from adder sum.
- add_cout  in  1  from adder cout.
- rsp_valid  out  NREQ  one-hot response strobe, one cycle, no backpressure.
- rsp_sum  out  8  result sum.
- rsp_cout  out  1  result carry-out.
- rsp_id  out  IDW  id of the responding requester.
- inflight  out  4  operations issued and not yet responded, 0..LATENCY+1.

Behaviour:
- Reset (async, rst=1): rr pointer = NREQ-1 (so req 0 has first priority), tag pipe cleared (all stage valids 0), rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, inflight=0. req_ready is 0 while rst=1.
- Arbitration (combinational):
  - Scan order starts at pointer+1 mod NREQ.
  - First requester with req_valid=1 gets req_ready=1; all others 0.
  - hold=1 or no valid requester: req_ready all 0.
  - At most one grant per cycle. No request is ever dropped; req_ready does not depend on anything but req_valid, hold and the pointer.
- Pointer update: on each issue edge, pointer = granted index. Otherwise unchanged.
- Adder drive:
  - add_a/add_b/add_cin are muxed combinationally from the granted requester.
  - When nothing is granted, drive 0/0/0; the tag marks the slot invalid.
- Tag pipe: LATENCY-stage shift register of {valid, id}, shifting every cycle regardless of hold.
  - Stage 0 loads {issue, granted id}.
  - Stage LATENCY-1 is aligned with add_sum/add_cout. An issue at cycle T gives an adder result during cycle T+LATENCY.
- Response register: when the last tag stage is valid, register add_sum/add_cout/id and assign rsp_valid = one-hot(id). Otherwise rsp_valid=0, and sum/cout/id hold their last values.
- Total latency: a handshake in cycle T gives rsp_valid in cycle T+LATENCY+1 (10 with defaults).
- Throughput: one response per cycle sustained. Responses come back in issue order.
- inflight: +1 on issue, -1 on rsp_valid. Both in the same cycle leaves it unchanged. Never wraps; max LATENCY+1.
- Boundary conditions:
  - A requester may drop req_valid without being granted; no state changes.
  - Operands are sampled only in the handshake cycle.
  - Wrap-around: pointer NREQ-1 scans from 0.
  - Single requester continuously valid is granted every cycle.
  - hold asserted mid-stream: issues stop next evaluation; queued results still return. inflight drains to 0 after LATENCY+1 cycles.
  - Reset mid-operation: all tags are invalidated and no response is produced for operations in flight. The adder pipeline itself is not reset; its stale contents are ignored because the tags are clear.
  - Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, a 9-bit result with no truncation.

Test Plan:
- Req 2 alone: a=8'h7F, b=8'h01, cin=0 at cycle T -> rsp_valid=4'b0100 at T+10, rsp_sum=8'h80, rsp_cout=0, rsp_id=2; inflight 1 from T+1 through T+10, then 0.
- Carry: req 0, a=8'hFF, b=8'h01, cin=1 -> rsp_sum=8'h01, rsp_cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum 8'hFF, cout 1.
- All four requesters continuously valid after reset -> grants 0,1,2,3,0,1... one per cycle; responses back-to-back from T+10 in the same id order; inflight saturates at 10.
- Req 1 and req 3 valid, pointer=1 -> req 3 granted, then req 1; hold=1 for 5 cycles -> req_ready=0 throughout, earlier results still arrive, inflight decrements to 0.
- Issue 6 ops, then assert rst for 1 cycle at issue+4 -> outputs at reset values immediately, no rsp_valid for any of the 6, inflight=0; a new issue after reset responds correctly 10 cycles later.
